fifo_read_port: RTL and testbench

Read-side consumer for the team's FIFO controller and its synchronous storage RAM. It watches the FIFO `empty` flag, issues `read_signal` pulses, captures the read data one cycle later, and presents it downstream on a valid/ready interface. A 2-entry output buffer sustains one word per cycle with no bubbles. The block sits between the FIFO storage and any downstream consumer such as a UART TX or a DMA sink.

---
 rtl/fifo_read_port.sv | 101 ++++++++++
 tb/tb_fifo_read_port.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_port.sv
// fifo_read_port
//
// Read-side consumer for the FIFO controller and its synchronous storage RAM.
// It issues read strobes while the FIFO is non-empty and there is room for the
// returning word. Words are captured one cycle after the strobe into a 2-entry
// output buffer, and are presented downstream on a valid/ready interface.
//
// Ports:
//   clk          single clock, rising-edge state updates
//   rst          asynchronous active-high reset
//   enable       permits new FIFO reads (level)
//   fifo_empty   FIFO empty flag from the controller
//   fifo_rdata   RAM read data, valid the cycle after read_signal
//   read_signal  read strobe to the FIFO controller (one pop per high cycle)
//   out_data     head word of the output buffer
//   out_valid    out_data is valid
//   out_ready    downstream accepts the word this cycle
//   word_count   number of words accepted downstream (wraps)
//   busy         a read is in flight or the buffer holds data
module fifo_read_port #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  read_signal,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
    logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic                  pend_q;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;

    logic                  pop;
    logic [2:0]            space;
    logic [1:0]            cap_pos;

    assign out_valid = (buf_cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;

    // Free entries once this cycle's pop and the in-flight word are accounted
    // for. Never negative, so the 3-bit wrap of the subtraction is harmless.
    assign space = 3'd2 - {1'b0, buf_cnt_q} - {2'b00, pend_q} + {2'b00, pop};

    // Depends on out_ready in the same cycle so a pop frees room immediately,
    // which is what allows one word per cycle with only two entries.
    assign read_signal = enable & ~fifo_empty & (space != 3'd0);

    // Position the returning word lands in, after any same-cycle shift.
    assign cap_pos = buf_cnt_q - {1'b0, pop};

    assign out_data   = slot0_q;
    assign word_count = word_count_q;
    assign busy       = pend_q | (buf_cnt_q != 2'd0);

    always_comb begin
        slot0_d      = slot0_q;
        slot1_d      = slot1_q;
        if (pop) begin
            slot0_d = slot1_q;
        end
        // A capture into position 0 overrides the shift above.
        if (pend_q) begin
            if (cap_pos == 2'd0) begin
                slot0_d = fifo_rdata;
            end else begin
                slot1_d = fifo_rdata;
            end
        end
        buf_cnt_d    = buf_cnt_q + {1'b0, pend_q} - {1'b0, pop};
        word_count_d = word_count_q + CNT_WIDTH'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q      <= '0;
            slot1_q      <= '0;
            buf_cnt_q    <= 2'd0;
            pend_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            slot0_q      <= slot0_d;
            slot1_q      <= slot1_d;
            buf_cnt_q    <= buf_cnt_d;
            pend_q       <= read_signal;
            word_count_q <= word_count_d;
        end
    end

    a_buf_cnt_range: assert property (@(posedge clk) disable iff (rst) buf_cnt_q <= 2'd2);

endmodule

// File: tb/tb_fifo_read_port.sv
module tb_fifo_read_port;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          read_signal;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] word_count;
    logic          busy;

    always #5 clk = ~clk;

    fifo_read_port #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .read_signal(read_signal),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count),
        .busy       (busy)
    );

    // FIFO storage + controller model: registered empty flag, RAM data one
    // cycle after a read strobe.
    logic [DW-1:0] mem[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.delete();
            fifo_empty <= 1'b1;
            fifo_rdata <= '0;
        end else begin
            if (read_signal && mem.size() > 0) fifo_rdata <= mem.pop_front();
            fifo_empty <= (mem.size() == 0);
        end
    end

    // Scoreboard: every word pushed must come out once, in order.
    logic [DW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int issued = 0;
    int delivered = 0;
    logic prev_read = 1'b0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic last_rd;
    logic last_valid;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic clear_model();
        exp_q.delete();
        issued = 0;
        delivered = 0;
        prev_read = 1'b0;
        prev_stall = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, then check the
    // observable state against the transaction-level counts.
    task automatic cycle(input logic rdy, input logic en);
        int outstanding;
        @(negedge clk);
        out_ready = rdy;
        enable = en;
        #1;
        outstanding = issued - delivered;
        check("busy", busy, outstanding != 0);
        check("out_valid", out_valid, (outstanding - int'(prev_read)) != 0);
        check("word_count", word_count, delivered % 16);
        check("read_while_empty", read_signal & fifo_empty, 0);
        if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
        end
        last_rd = read_signal;
        last_valid = out_valid;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_word", out_data, 32'hFFFF_FFFF);
            else check("out_data", out_data, exp_q.pop_front());
            delivered++;
        end
        prev_stall = out_valid & ~out_ready;
        prev_data = out_data;
        prev_read = read_signal;
        if (read_signal) issued++;
        check("buffer_bound", (issued - delivered) <= 2, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read_signal"}, read_signal, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int reads;
        int first_v;
        int last_v;
        int base;
        logic [DW-1:0] head;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        reads = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1);
            if (last_rd) reads++;
        end
        check("idle_reads", reads, 0);

        // Single word
        push(8'hA5);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
        check("single_delivered", delivered, 1);
        check("single_busy", busy, 0);

        // Streaming 0x01..0x07
        base = delivered;
        for (int i = 1; i <= 7; i++) push(DW'(i));
        reads = 0;
        first_v = -1;
        last_v = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b1);
            if (last_rd) reads++;
            if (last_valid) begin
                if (first_v < 0) first_v = i;
                last_v = i;
            end
        end
        check("stream_reads", reads, 7);
        check("stream_no_gaps", last_v - first_v, 6);
        check("stream_delivered", delivered - base, 7);

        // Backpressure: 5 words, downstream stalled for 10 cycles
        base = delivered;
        for (int i = 0; i < 5; i++) push(DW'(8'h50 + i));
        head = 8'h50;
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1);
            if (last_rd) reads++;
        end
        check("bp_reads", reads, 2);
        check("bp_valid", out_valid, 1);
        check("bp_head", out_data, head);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
        check("bp_delivered", delivered - base, 5);

        // Enable drop right after a read
        base = delivered;
        for (int i = 0; i < 3; i++) push(DW'(8'hE0 + i));
        cycle(1'b1, 1'b1);
        check("en_read", last_rd, 1);
        reads = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0);
            if (last_rd) reads++;
        end
        check("en_no_reads", reads, 0);
        check("en_delivered", delivered - base, 1);
        check("en_busy", busy, 0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);
        check("en_flush", delivered - base, 3);

        // Mid-transfer reset with a full buffer
        for (int i = 0; i < 4; i++) push(DW'(8'h90 + i));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        check("pre_reset_valid", out_valid, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        push(8'h3C);
        first_v = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid && first_v == 0) begin
                check("post_reset_first", out_data, 8'h3C);
                first_v = 1;
            end
            cycle(1'b1, 1'b1);
        end
        check("post_reset_seen", first_v, 1);
        check("post_reset_delivered", delivered, 1);

        // Counter wrap after 16 pops (15 more on top of the one above)
        for (int i = 0; i < 15; i++) push(DW'($urandom));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
        check("wrap_delivered", delivered, 16);
        check("wrap_count", word_count, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) push(DW'($urandom));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0));
        end
        for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) cycle(1'b1, 1'b1);
        check("drain_empty", exp_q.size(), 0);
        check("drain_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
